// File: rtl/cpu_control_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_pkg
// Purpose  : Shared states, instruction classes, opcodes and strobe bit indices
//            for the hardwired CPU control sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RST       = 4'd0,
        ST_F0        = 4'd1,
        ST_FW        = 4'd2,
        ST_F1        = 4'd3,
        ST_F2        = 4'd4,
        ST_E3        = 4'd5,
        ST_E4        = 4'd6,
        ST_E5        = 4'd7,
        ST_EW        = 4'd8,
        ST_E6        = 4'd9,
        ST_E7        = 4'd10,
        ST_HALT      = 4'd11,
        ST_WAIT_STEP = 4'd12
    } state_t;

    typedef enum logic [3:0] {
        CL_LD     = 4'd0,
        CL_LDI    = 4'd1,
        CL_ST     = 4'd2,
        CL_ALU_R  = 4'd3,
        CL_ALU_I  = 4'd4,
        CL_MULDIV = 4'd5,
        CL_UNARY  = 4'd6,
        CL_BR     = 4'd7,
        CL_JR     = 4'd8,
        CL_IN     = 4'd9,
        CL_OUT    = 4'd10,
        CL_MFHI   = 4'd11,
        CL_MFLO   = 4'd12,
        CL_NOP    = 4'd13,
        CL_HALT   = 4'd14
    } iclass_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_IN   = 5'b10101;
    localparam logic [4:0] OP_OUT  = 5'b10110;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    localparam logic [4:0] ALU_ADD = 5'b00011;

    localparam int unsigned SRC_COUT   = 7;
    localparam int unsigned SRC_INPORT = 6;
    localparam int unsigned SRC_LOOUT  = 5;
    localparam int unsigned SRC_HIOUT  = 4;
    localparam int unsigned SRC_ZLOOUT = 3;
    localparam int unsigned SRC_ZHIOUT = 2;
    localparam int unsigned SRC_MDROUT = 1;
    localparam int unsigned SRC_PCOUT  = 0;

    localparam int unsigned DST_CONIN  = 9;
    localparam int unsigned DST_OPIN   = 8;
    localparam int unsigned DST_LOIN   = 7;
    localparam int unsigned DST_HIIN   = 6;
    localparam int unsigned DST_ZIN    = 5;
    localparam int unsigned DST_YIN    = 4;
    localparam int unsigned DST_MDRIN  = 3;
    localparam int unsigned DST_MARIN  = 2;
    localparam int unsigned DST_IRIN   = 1;
    localparam int unsigned DST_PCIN   = 0;

    localparam int unsigned REG_BAOUT  = 5;
    localparam int unsigned REG_ROUT   = 4;
    localparam int unsigned REG_RIN    = 3;
    localparam int unsigned REG_GRC    = 2;
    localparam int unsigned REG_GRB    = 1;
    localparam int unsigned REG_GRA    = 0;

endpackage
`default_nettype wire

// File: rtl/cpu_control_sequencer_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_opcode_decode
// Purpose  : Maps IR[31:27] to an instruction class; undefined opcodes map to
//            the nop class with the illegal flag raised.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_opcode_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output iclass_t    iclass,
    output logic       illegal
);

    always_comb begin
        iclass  = CL_NOP;
        illegal = 1'b0;
        case (opcode)
            OP_LD:   iclass = CL_LD;
            OP_LDI:  iclass = CL_LDI;
            OP_ST:   iclass = CL_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL:
                     iclass = CL_ALU_R;
            OP_ADDI, OP_ANDI, OP_ORI:
                     iclass = CL_ALU_I;
            OP_MUL, OP_DIV:
                     iclass = CL_MULDIV;
            OP_NEG, OP_NOT:
                     iclass = CL_UNARY;
            OP_BR:   iclass = CL_BR;
            OP_JR:   iclass = CL_JR;
            OP_IN:   iclass = CL_IN;
            OP_OUT:  iclass = CL_OUT;
            OP_MFHI: iclass = CL_MFHI;
            OP_MFLO: iclass = CL_MFLO;
            OP_NOP:  iclass = CL_NOP;
            OP_HALT: iclass = CL_HALT;
            default: illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_control_sequencer
// Purpose  : Hardwired Moore control unit: fetch / decode / execute sequencing
//            of every datapath strobe. Optional SINGLE_STEP_EN adds a step input.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_RD_LAT = 1
) (
    input  logic        clk,
    input  logic        clr,
`ifdef SINGLE_STEP_EN
    input  logic        step,
`endif
    input  logic [31:0] ir,
    input  logic        con_ff,
    output logic [7:0]  src_sel,
    output logic [9:0]  dst_en,
    output logic [5:0]  reg_ctl,
    output logic        IncPC,
    output logic        MDRread,
    output logic        wren,
    output logic [4:0]  ALUSelection,
    output logic        instr_done,
    output logic        halted,
    output logic        illegal_op
);

    localparam logic       c_HAS_WAIT = (MEM_RD_LAT != 0);
    localparam logic [1:0] c_LAT_LAST = 2'(MEM_RD_LAT - 1);
`ifdef SINGLE_STEP_EN
    localparam state_t     c_DONE_STATE = ST_WAIT_STEP;
`else
    localparam state_t     c_DONE_STATE = ST_F0;
`endif

    state_t     r_state;
    state_t     w_next;
    state_t     w_last_state;
    logic [1:0] r_wait_cnt;
    logic       r_illegal;
    iclass_t    w_class;
    logic       w_illegal;
    logic       w_last;
    logic [4:0] w_op;
    logic       w_unused_ir;

    assign w_op        = ir[31:27];
    assign w_unused_ir = ^ir[26:0];

    ctrl_opcode_decode u_decode (
        .opcode  (w_op),
        .iclass  (w_class),
        .illegal (w_illegal)
    );

`ifdef SINGLE_STEP_EN
    logic r_step_d;
    logic w_step_go;
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) r_step_d <= 1'b0;
        else      r_step_d <= step;
    end
    assign w_step_go = step & ~r_step_d;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state    <= ST_RST;
            r_wait_cnt <= 2'd0;
            r_illegal  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= (r_state == ST_FW || r_state == ST_EW) ? r_wait_cnt + 2'd1 : 2'd0;
            if (r_state == ST_E3 && w_illegal)
                r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_last_state = ST_E3;
        case (w_class)
            CL_LD, CL_ST:                w_last_state = ST_E7;
            CL_LDI, CL_ALU_R, CL_ALU_I:  w_last_state = ST_E5;
            CL_MULDIV, CL_BR:            w_last_state = ST_E6;
            CL_UNARY:                    w_last_state = ST_E4;
            default:                     w_last_state = ST_E3;
        endcase
    end

    assign w_last = (r_state == w_last_state);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RST:  w_next = ST_F0;
            ST_F0:   w_next = c_HAS_WAIT ? ST_FW : ST_F1;
            ST_FW:   if (r_wait_cnt == c_LAT_LAST) w_next = ST_F1;
            ST_F1:   w_next = ST_F2;
            ST_F2:   w_next = ST_E3;
            ST_E3, ST_E4, ST_E5, ST_E6, ST_E7: begin
                if (w_last)
                    w_next = (w_class == CL_HALT) ? ST_HALT : c_DONE_STATE;
                else if (r_state == ST_E3)
                    w_next = ST_E4;
                else if (r_state == ST_E4)
                    w_next = ST_E5;
                else if (r_state == ST_E5)
                    w_next = (w_class == CL_LD && c_HAS_WAIT) ? ST_EW : ST_E6;
                else if (r_state == ST_E6)
                    w_next = ST_E7;
                else
                    w_next = ST_F0;
            end
            ST_EW:   if (r_wait_cnt == c_LAT_LAST) w_next = ST_E6;
            ST_HALT: w_next = ST_HALT;
`ifdef SINGLE_STEP_EN
            ST_WAIT_STEP: if (w_step_go) w_next = ST_F0;
`else
            ST_WAIT_STEP: w_next = ST_F0;
`endif
            default: w_next = ST_RST;
        endcase
    end

    // Strobe decode: one control word per state, refined by instruction class.
    always_comb begin
        src_sel      = 8'd0;
        dst_en       = 10'd0;
        reg_ctl      = 6'd0;
        IncPC        = 1'b0;
        MDRread      = 1'b0;
        wren         = 1'b0;
        ALUSelection = 5'd0;
        case (r_state)
            ST_F0: begin
                src_sel[SRC_PCOUT] = 1'b1;
                dst_en[DST_MARIN]  = 1'b1;
                IncPC              = 1'b1;
            end
            ST_F1: begin
                MDRread            = 1'b1;
                dst_en[DST_MDRIN]  = 1'b1;
            end
            ST_F2: begin
                src_sel[SRC_MDROUT] = 1'b1;
                dst_en[DST_IRIN]    = 1'b1;
            end
            ST_E3: begin
                case (w_class)
                    CL_LD, CL_LDI, CL_ST: begin
                        reg_ctl[REG_GRB] = 1'b1; reg_ctl[REG_BAOUT] = 1'b1; dst_en[DST_YIN] = 1'b1;
                    end
                    CL_ALU_R, CL_ALU_I: begin
                        reg_ctl[REG_GRB] = 1'b1; reg_ctl[REG_ROUT] = 1'b1; dst_en[DST_YIN] = 1'b1;
                    end
                    CL_MULDIV: begin
                        reg_ctl[REG_GRA] = 1'b1; reg_ctl[REG_ROUT] = 1'b1; dst_en[DST_YIN] = 1'b1;
                    end
                    CL_UNARY: begin
                        reg_ctl[REG_GRB] = 1'b1; reg_ctl[REG_ROUT] = 1'b1; dst_en[DST_ZIN] = 1'b1;
                        ALUSelection = w_op;
                    end
                    CL_BR: begin
                        reg_ctl[REG_GRA] = 1'b1; reg_ctl[REG_ROUT] = 1'b1; dst_en[DST_CONIN] = 1'b1;
                    end
                    CL_JR: begin
                        reg_ctl[REG_GRA] = 1'b1; reg_ctl[REG_ROUT] = 1'b1; dst_en[DST_PCIN] = 1'b1;
                    end
                    CL_IN: begin
                        src_sel[SRC_INPORT] = 1'b1; reg_ctl[REG_GRA] = 1'b1; reg_ctl[REG_RIN] = 1'b1;
                    end
                    CL_OUT: begin
                        reg_ctl[REG_GRA] = 1'b1; reg_ctl[REG_ROUT] = 1'b1; dst_en[DST_OPIN] = 1'b1;
                    end
                    CL_MFHI: begin
                        src_sel[SRC_HIOUT] = 1'b1; reg_ctl[REG_GRA] = 1'b1; reg_ctl[REG_RIN] = 1'b1;
                    end
                    CL_MFLO: begin
                        src_sel[SRC_LOOUT] = 1'b1; reg_ctl[REG_GRA] = 1'b1; reg_ctl[REG_RIN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_E4: begin
                case (w_class)
                    CL_LD, CL_LDI, CL_ST: begin
                        src_sel[SRC_COUT] = 1'b1; dst_en[DST_ZIN] = 1'b1; ALUSelection = ALU_ADD;
                    end
                    CL_ALU_R: begin
                        reg_ctl[REG_GRC] = 1'b1; reg_ctl[REG_ROUT] = 1'b1; dst_en[DST_ZIN] = 1'b1;
                        ALUSelection = w_op;
                    end
                    CL_ALU_I: begin
                        src_sel[SRC_COUT] = 1'b1; dst_en[DST_ZIN] = 1'b1; ALUSelection = w_op;
                    end
                    CL_MULDIV: begin
                        reg_ctl[REG_GRB] = 1'b1; reg_ctl[REG_ROUT] = 1'b1; dst_en[DST_ZIN] = 1'b1;
                        ALUSelection = w_op;
                    end
                    CL_UNARY: begin
                        src_sel[SRC_ZLOOUT] = 1'b1; reg_ctl[REG_GRA] = 1'b1; reg_ctl[REG_RIN] = 1'b1;
                    end
                    CL_BR: begin
                        src_sel[SRC_PCOUT] = 1'b1; dst_en[DST_YIN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_E5: begin
                case (w_class)
                    CL_LD, CL_ST: begin
                        src_sel[SRC_ZLOOUT] = 1'b1; dst_en[DST_MARIN] = 1'b1;
                    end
                    CL_LDI, CL_ALU_R, CL_ALU_I: begin
                        src_sel[SRC_ZLOOUT] = 1'b1; reg_ctl[REG_GRA] = 1'b1; reg_ctl[REG_RIN] = 1'b1;
                    end
                    CL_MULDIV: begin
                        src_sel[SRC_ZLOOUT] = 1'b1; dst_en[DST_LOIN] = 1'b1;
                    end
                    CL_BR: begin
                        src_sel[SRC_COUT] = 1'b1; dst_en[DST_ZIN] = 1'b1; ALUSelection = ALU_ADD;
                    end
                    default: ;
                endcase
            end
            ST_E6: begin
                case (w_class)
                    CL_LD: begin
                        MDRread = 1'b1; dst_en[DST_MDRIN] = 1'b1;
                    end
                    CL_ST: begin
                        reg_ctl[REG_GRA] = 1'b1; reg_ctl[REG_ROUT] = 1'b1; dst_en[DST_MDRIN] = 1'b1;
                    end
                    CL_MULDIV: begin
                        src_sel[SRC_ZHIOUT] = 1'b1; dst_en[DST_HIIN] = 1'b1;
                    end
                    CL_BR: begin
                        src_sel[SRC_ZLOOUT] = 1'b1; dst_en[DST_PCIN] = con_ff;
                    end
                    default: ;
                endcase
            end
            ST_E7: begin
                if (w_class == CL_LD) begin
                    src_sel[SRC_MDROUT] = 1'b1; reg_ctl[REG_GRA] = 1'b1; reg_ctl[REG_RIN] = 1'b1;
                end else if (w_class == CL_ST) begin
                    wren = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign instr_done = w_last;
    assign halted     = (r_state == ST_HALT);
    assign illegal_op = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_control_sequencer
// Purpose  : Self-checking bench: per-cycle control-word model, vector table,
//            halt / mid-instruction reset sequences and random instruction mix.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_control_sequencer;

    localparam int LAT = 1;

    localparam logic [7:0] S_C = 8'h80, S_IN = 8'h40, S_LO = 8'h20, S_HI = 8'h10;
    localparam logic [7:0] S_ZLO = 8'h08, S_ZHI = 8'h04, S_MDR = 8'h02, S_PC = 8'h01;
    localparam logic [9:0] D_CON = 10'h200, D_OP = 10'h100, D_LO = 10'h080, D_HI = 10'h040;
    localparam logic [9:0] D_Z = 10'h020, D_Y = 10'h010, D_MDR = 10'h008, D_MAR = 10'h004;
    localparam logic [9:0] D_IR = 10'h002, D_PC = 10'h001;
    localparam logic [5:0] R_BA = 6'h20, R_OUT = 6'h10, R_IN = 6'h08;
    localparam logic [5:0] R_C = 6'h04, R_B = 6'h02, R_A = 6'h01;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] ir = 32'd0;
    logic        con_ff = 1'b0;
    logic [7:0]  src_sel;
    logic [9:0]  dst_en;
    logic [5:0]  reg_ctl;
    logic        IncPC, MDRread, wren, instr_done, halted, illegal_op;
    logic [4:0]  ALUSelection;

    always #5 clk = ~clk;

    cpu_control_sequencer #(.MEM_RD_LAT(LAT)) dut (
        .clk          (clk),
        .clr          (clr),
        .ir           (ir),
        .con_ff       (con_ff),
        .src_sel      (src_sel),
        .dst_en       (dst_en),
        .reg_ctl      (reg_ctl),
        .IncPC        (IncPC),
        .MDRread      (MDRread),
        .wren         (wren),
        .ALUSelection (ALUSelection),
        .instr_done   (instr_done),
        .halted       (halted),
        .illegal_op   (illegal_op)
    );

    typedef struct packed {
        logic [7:0] src;
        logic [9:0] dst;
        logic [5:0] rc;
        logic       inc;
        logic       mrd;
        logic       wr;
        logic [4:0] alu;
        logic       done;
        logic       hlt;
    } ctl_t;

    typedef struct {
        logic [31:0] ir;
        logic        cf;
        int          cycles;
    } vec_t;

    ctl_t act;
    assign act = {src_sel, dst_en, reg_ctl, IncPC, MDRread, wren, ALUSelection, instr_done, halted};

    ctl_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_ill = 1'b0;
    vec_t tbl[21];

    task automatic push(input logic [7:0] s, input logic [9:0] d, input logic [5:0] r,
                        input logic [4:0] a, input logic [2:0] f);
        ctl_t c;
        c = '0;
        c.src = s; c.dst = d; c.rc = r; c.alu = a;
        {c.inc, c.mrd, c.wr} = f;
        exp_q.push_back(c);
    endtask

    function automatic logic is_undef(input logic [4:0] op);
        return (op == 5'd20) || (op >= 5'd27);
    endfunction

    // Expected control word of every cycle of one instruction, fetch included.
    task automatic build(input logic [4:0] op, input logic cf);
        exp_q.delete();
        push(S_PC, D_MAR, '0, '0, 3'b100);
        for (int w = 0; w < LAT; w++) push('0, '0, '0, '0, 3'b000);
        push('0, D_MDR, '0, '0, 3'b010);
        push(S_MDR, D_IR, '0, '0, 3'b000);
        if (op <= 5'd2) begin
            push('0, D_Y, R_B | R_BA, '0, 3'b000);
            push(S_C, D_Z, '0, 5'd3, 3'b000);
            if (op == 5'd1) begin
                push(S_ZLO, '0, R_A | R_IN, '0, 3'b000);
            end else begin
                push(S_ZLO, D_MAR, '0, '0, 3'b000);
                if (op == 5'd0) begin
                    for (int w = 0; w < LAT; w++) push('0, '0, '0, '0, 3'b000);
                    push('0, D_MDR, '0, '0, 3'b010);
                    push(S_MDR, '0, R_A | R_IN, '0, 3'b000);
                end else begin
                    push('0, D_MDR, R_A | R_OUT, '0, 3'b000);
                    push('0, '0, '0, '0, 3'b001);
                end
            end
        end else if (op <= 5'd13) begin
            push('0, D_Y, R_B | R_OUT, '0, 3'b000);
            if (op <= 5'd10) push('0, D_Z, R_C | R_OUT, op, 3'b000);
            else             push(S_C, D_Z, '0, op, 3'b000);
            push(S_ZLO, '0, R_A | R_IN, '0, 3'b000);
        end else if (op <= 5'd15) begin
            push('0, D_Y, R_A | R_OUT, '0, 3'b000);
            push('0, D_Z, R_B | R_OUT, op, 3'b000);
            push(S_ZLO, D_LO, '0, '0, 3'b000);
            push(S_ZHI, D_HI, '0, '0, 3'b000);
        end else if (op <= 5'd17) begin
            push('0, D_Z, R_B | R_OUT, op, 3'b000);
            push(S_ZLO, '0, R_A | R_IN, '0, 3'b000);
        end else begin
            case (op)
                5'd18: begin
                    push('0, D_CON, R_A | R_OUT, '0, 3'b000);
                    push(S_PC, D_Y, '0, '0, 3'b000);
                    push(S_C, D_Z, '0, 5'd3, 3'b000);
                    push(S_ZLO, cf ? D_PC : 10'h000, '0, '0, 3'b000);
                end
                5'd19:   push('0, D_PC, R_A | R_OUT, '0, 3'b000);
                5'd21:   push(S_IN, '0, R_A | R_IN, '0, 3'b000);
                5'd22:   push('0, D_OP, R_A | R_OUT, '0, 3'b000);
                5'd23:   push(S_HI, '0, R_A | R_IN, '0, 3'b000);
                5'd24:   push(S_LO, '0, R_A | R_IN, '0, 3'b000);
                default: push('0, '0, '0, '0, 3'b000);
            endcase
        end
        exp_q[exp_q.size() - 1].done = 1'b1;
    endtask

    task automatic check(input ctl_t e, input string nm, input int k);
        n_cmp++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h expected %h", nm, k, act, e);
        end
        n_cmp++;
        if ($countones(src_sel) > 1 || (reg_ctl[4] && (src_sel != 8'd0 || reg_ctl[5]))) begin
            n_bad++;
            $display("FAIL invariant %s step %0d: src_sel=%b reg_ctl=%b", nm, k, src_sel, reg_ctl);
        end
    endtask

    task automatic check_ill(input string nm);
        n_cmp++;
        if (illegal_op !== exp_ill) begin
            n_bad++;
            $display("FAIL illegal_op %s: got %b expected %b", nm, illegal_op, exp_ill);
        end
    endtask

    task automatic do_instr(input logic [31:0] iv, input logic cf, output int done_at);
        logic [4:0] op;
        string      nm;
        op = iv[31:27];
        nm = $sformatf("op%0d_ir%h_cf%0d", op, iv, cf);
        @(posedge clk);
        #1;
        ir = iv;
        con_ff = cf;
        build(op, cf);
        done_at = -1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            if (k == 0) check_ill(nm);
            check(exp_q[k], nm, k);
            if (instr_done === 1'b1 && done_at < 0) done_at = k + 1;
        end
        if (is_undef(op)) exp_ill = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 clr = 1'b0;
        exp_ill = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check('0, "in_reset", i);
            check_ill("in_reset");
        end
        @(posedge clk);
        #1 clr = 1'b1;
        @(negedge clk);
        check('0, "rst_state", 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   d;
        ctl_t hw;

        tbl[0]  = '{32'h18918000, 1'b0, 7};
        tbl[1]  = '{32'h00880010, 1'b0, 10};
        tbl[2]  = '{32'h08880010, 1'b0, 7};
        tbl[3]  = '{32'h10880010, 1'b0, 9};
        tbl[4]  = '{32'h20918000, 1'b0, 7};
        tbl[5]  = '{32'h48918000, 1'b0, 7};
        tbl[6]  = '{32'h58880005, 1'b0, 7};
        tbl[7]  = '{32'h68880005, 1'b0, 7};
        tbl[8]  = '{32'h70900000, 1'b0, 8};
        tbl[9]  = '{32'h78900000, 1'b0, 8};
        tbl[10] = '{32'h80900000, 1'b0, 6};
        tbl[11] = '{32'h88900000, 1'b0, 6};
        tbl[12] = '{32'h90800004, 1'b0, 8};
        tbl[13] = '{32'h90800004, 1'b1, 8};
        tbl[14] = '{32'h98800000, 1'b0, 5};
        tbl[15] = '{32'hA8800000, 1'b0, 5};
        tbl[16] = '{32'hB0800000, 1'b0, 5};
        tbl[17] = '{32'hB8800000, 1'b0, 5};
        tbl[18] = '{32'hC0800000, 1'b0, 5};
        tbl[19] = '{32'hF8000000, 1'b0, 5};
        tbl[20] = '{32'hA0000000, 1'b0, 5};

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check('0, "por_reset", i);
            check_ill("por_reset");
        end
        @(posedge clk);
        #1 clr = 1'b1;
        @(negedge clk);
        check('0, "por_rst_state", 0);

        for (int i = 0; i < 21; i++) begin
            do_instr(tbl[i].ir, tbl[i].cf, d);
            n_cmp++;
            if (d != tbl[i].cycles) begin
                n_bad++;
                $display("FAIL latency vec%0d ir=%h: done after %0d cycles, expected %0d",
                         i, tbl[i].ir, d, tbl[i].cycles);
            end
        end
        do_instr(32'h18918000, 1'b0, d);

        // halt: stays parked with no strobes until reset
        do_instr(32'hD0000000, 1'b0, d);
        hw = '0;
        hw.hlt = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check(hw, "halt_park", i);
        end
        do_reset();
        do_instr(32'h18918000, 1'b0, d);

        // reset during the write step of st
        @(posedge clk);
        #1 ir = 32'h10880010;
        con_ff = 1'b0;
        build(5'd2, 1'b0);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            check(exp_q[k], "st_before_clr", k);
        end
        #1 clr = 1'b0;
        #1 check('0, "clr_during_st_e7", 0);
        exp_ill = 1'b0;
        @(posedge clk);
        #1 clr = 1'b1;
        @(negedge clk);
        check('0, "rst_after_clr", 0);
        do_instr(32'h18918000, 1'b0, d);

        for (int i = 0; i < 40; i++) begin
            logic [4:0] op;
            op = 5'($urandom_range(0, 31));
            if (op == 5'd26) op = 5'd25;
            do_instr({op, 27'($urandom)}, 1'($urandom_range(0, 1)), d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
